// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and default timing constants for the WS2812
//               receiver (decoder state encoding, nominal 24 MHz timings).
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Decoder states. The encoding is exported on in_debug[12:11].
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,  // waiting for a full frame gap before arming
        ST_IDLE = 2'd1,  // armed, line low after a gap
        ST_HIGH = 2'd2,  // measuring a high pulse
        ST_LOW  = 2'd3   // measuring the low time after a bit
    } state_t;

    // Default timings in clk cycles at 24 MHz.
    localparam int c_DEF_BIT_THRESHOLD = 14;
    localparam int c_DEF_MIN_HIGH      = 3;
    localparam int c_DEF_MAX_HIGH      = 48;
    localparam int c_DEF_RESET_CYCLES  = 1200;

endpackage : ws2812_pkg
`default_nettype wire

// File: rtl/ws2812_sync.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_sync
// Description : Two-flop synchronizer for the raw WS2812 line, plus
//               single-cycle rise/fall strobes of the synchronized level.
// Ports       : clk, rst (async, active-low), i_async (raw line),
//               o_s (synchronized level), o_rise / o_fall (edge strobes,
//               high in the first cycle o_s shows the new level).
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_s;
    logic r_s_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_s_d  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_s    <= r_meta;
            r_s_d  <= r_s;
        end
    end

    assign o_s    = r_s;
    assign o_rise = r_s & ~r_s_d;
    assign o_fall = ~r_s & r_s_d;

endmodule : ws2812_sync
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_rx
// Description : WS2812 serial-line receiver. Measures high-pulse widths on
//               the synchronized line, decodes bits MSB first into bytes and
//               delimits frames by long low gaps.
// Ports       : clk, rst (async, active-low)
//               in_input    - raw data line
//               max_bytes   - per-frame byte limit (0 = accept none)
//               byte_data / byte_addr / byte_valid - decoded byte strobe
//               frame_start / frame_done - frame delimiting strobes
//               byte_count  - bytes emitted in the last completed frame
//               overflow    - sticky, bytes dropped in the current frame
//               in_debug    - {state, glitch, err, bit_cnt, high_cnt}
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESHOLD = c_DEF_BIT_THRESHOLD,
    parameter int MIN_HIGH      = c_DEF_MIN_HIGH,
    parameter int MAX_HIGH      = c_DEF_MAX_HIGH,
    parameter int RESET_CYCLES  = c_DEF_RESET_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_input,
    input  logic [7:0]  max_bytes,
    output logic [7:0]  byte_data,
    output logic [7:0]  byte_addr,
    output logic        byte_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic [7:0]  byte_count,
    output logic        overflow,
    output logic [12:0] in_debug
);

    localparam int               c_LOW_W = $clog2(RESET_CYCLES + 1);
    localparam logic [c_LOW_W-1:0] c_RC  = c_LOW_W'(RESET_CYCLES);
    localparam logic [c_LOW_W-1:0] c_ONE = c_LOW_W'(1);
    localparam logic [5:0]       c_THR   = 6'(BIT_THRESHOLD);
    localparam logic [5:0]       c_MIN   = 6'(MIN_HIGH);
    localparam logic [5:0]       c_MAX   = 6'(MAX_HIGH);

    logic w_s, w_rise, w_fall;

    state_t               r_state, w_state_next;
    logic [5:0]           r_high_cnt;
    logic [c_LOW_W-1:0]   r_low_cnt, w_low_cnt_next, w_low_inc;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shreg, w_shreg_next;
    logic [7:0]           r_addr;
    logic                 r_from_idle;
    logic                 r_glitch, r_err;
    logic [7:0]           r_byte_data, r_byte_addr, r_byte_count;
    logic                 r_byte_valid, r_frame_start, r_frame_done, r_overflow;

    logic w_frame_start, w_frame_done, w_shift, w_glitch, w_err;
    logic w_bit, w_byte_done, w_emit;

    ws2812_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (in_input),
        .o_s     (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Low-time counters include the current cycle, so a gap of exactly
    // RESET_CYCLES low cycles is recognised in its last low cycle.
    assign w_low_inc    = r_low_cnt + c_ONE;
    assign w_bit        = (r_high_cnt >= c_THR);
    assign w_shreg_next = {r_shreg[6:0], w_bit};
    assign w_byte_done  = w_shift && (r_bit_cnt == 3'd7);
    assign w_emit       = w_byte_done && (r_addr < max_bytes);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_SYNC;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_low_cnt_next = r_low_cnt;
        w_frame_start  = 1'b0;
        w_frame_done   = 1'b0;
        w_shift        = 1'b0;
        w_glitch       = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_s) begin
                    w_low_cnt_next = '0;
                end else if (w_low_inc >= c_RC) begin
                    w_low_cnt_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_low_cnt_next = w_low_inc;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next  = ST_HIGH;
                    w_frame_start = 1'b1;
                end
            end
            ST_HIGH: begin
                if (r_high_cnt > c_MAX) begin
                    w_err          = 1'b1;
                    w_low_cnt_next = '0;
                    w_state_next   = ST_SYNC;
                end else if (w_fall) begin
                    // The fall cycle is the first low cycle of the gap.
                    w_low_cnt_next = c_ONE;
                    if (r_high_cnt < c_MIN) begin
                        w_glitch     = 1'b1;
                        w_state_next = r_from_idle ? ST_IDLE : ST_LOW;
                    end else begin
                        w_shift      = 1'b1;
                        w_state_next = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_next = ST_HIGH;
                end else if (w_low_inc >= c_RC) begin
                    w_frame_done   = 1'b1;
                    w_low_cnt_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_low_cnt_next = w_low_inc;
                end
            end
            default: w_state_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_addr        <= '0;
            r_from_idle   <= 1'b0;
            r_glitch      <= 1'b0;
            r_err         <= 1'b0;
            r_byte_data   <= '0;
            r_byte_addr   <= '0;
            r_byte_count  <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_low_cnt     <= w_low_cnt_next;
            r_glitch      <= w_glitch;
            r_err         <= w_err;
            r_frame_start <= w_frame_start;
            r_frame_done  <= w_frame_done;
            r_byte_valid  <= w_emit;

            // The rise cycle is the first high cycle, so at the fall
            // high_cnt equals the pulse width in cycles.
            if (w_rise && (r_state == ST_IDLE || r_state == ST_LOW))
                r_high_cnt <= 6'd1;
            else if (r_state == ST_HIGH && w_s && r_high_cnt != 6'h3f)
                r_high_cnt <= r_high_cnt + 6'd1;

            // Remember where a pulse started so a glitch can return there.
            if (w_rise && r_state == ST_IDLE)
                r_from_idle <= 1'b1;
            else if (w_rise && r_state == ST_LOW)
                r_from_idle <= 1'b0;

            if (w_frame_start) begin
                r_bit_cnt   <= '0;
                r_addr      <= '0;
                r_byte_addr <= '0;
                r_overflow  <= 1'b0;
            end else if (w_shift) begin
                r_shreg   <= w_shreg_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_err || w_frame_done) begin
                r_bit_cnt <= '0;
            end

            if (w_emit) begin
                r_byte_data <= w_shreg_next;
                r_byte_addr <= r_addr;
                if (r_addr != 8'hff)
                    r_addr <= r_addr + 8'd1;
            end else if (w_byte_done) begin
                r_overflow <= 1'b1;
            end

            if (w_frame_done)
                r_byte_count <= r_addr;
        end
    end

    assign byte_data   = r_byte_data;
    assign byte_addr   = r_byte_addr;
    assign byte_valid  = r_byte_valid;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign byte_count  = r_byte_count;
    assign overflow    = r_overflow;
    assign in_debug    = {r_state, r_glitch, r_err, r_bit_cnt, r_high_cnt};

endmodule : ws2812_rx
`default_nettype wire
